float_mul_pipe_mul: RTL
=======================

FLOAT_MUL_PIPE_MUL -- requirements
Module: float_mul_pipe_mul

Interface
REQ-001 The block SHALL expose the following ports: clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 en  input  1  pipeline advance enable; 0 = stall and hold all registers.
REQ-004 flush  input  1  synchronous kill of all in-flight valid bits.
REQ-005 in_valid  input  1  operands a, b and rm are valid this cycle.
REQ-006 a, b  input  32 each  IEEE-754 single-precision operands.
REQ-007 rm  input  2  rounding mode, carried unchanged: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero.
REQ-008 n_valid  output  1  stage-2 result valid.
REQ-009 n_rm  output  2  rounding mode of the stage-2 result.
REQ-010 n_sign  output  1  sign of the product, a[31]^b[31].
REQ-011 n_exp10  output  10  biased product exponent, two's complement.
REQ-012 n_is_inf_nan  output  1  result is infinity or NaN.
REQ-013 n_inf_nan_frac  output  23  fraction to emit when n_is_inf_nan=1.
REQ-014 n_z  output  48  unnormalised 24x24 significand product.

Function
REQ-015 Unpack: hidden bit = |exp; exponent field 0 SHALL be used as effective exponent 1; fraction = {hidden, frac[22:0]}.
REQ-016 n_exp10 SHALL equal ea_eff + eb_eff - 127, computed in 10 bits modulo 1024. Example: 1 + 1 - 127 = 0x383.
REQ-017 A NaN operand, or infinity x zero, SHALL give n_is_inf_nan=1 and n_inf_nan_frac=0x400000.
REQ-018 Infinity x nonzero finite, or infinity x infinity, SHALL give n_is_inf_nan=1 and n_inf_nan_frac=0.
REQ-019 In all other cases n_is_inf_nan=0 and n_inf_nan_frac=0.
REQ-020 Stage 1 registers, on an enabled edge:
  - unpacked sign, exp10, inf/nan flags and rm;
  - pp_lo = fa*fb[11:0] (36 bit);
  - pp_hi = fa*fb[23:12] (36 bit);
  - v1 = in_valid.
REQ-021 Stage 2 registers n_z = pp_lo + (pp_hi<<12) in 48 bits, with no truncation, and forwards all other stage-1 fields; n_valid = v1.
REQ-022 Latency SHALL be exactly 2 enabled edges: an operand sampled with en=1 at edge k appears on the outputs after the next enabled edge. Stall cycles add latency 1:1.
REQ-023 Stages SHALL load data regardless of in_valid; only the valid bits qualify results.
REQ-024 With en=0 every register SHALL hold, including the data and the valid bits.
REQ-025 flush=1 SHALL clear v1 and n_valid at the edge regardless of en; data registers are unaffected.
REQ-026 flush has priority over en and in_valid when asserted simultaneously.
REQ-027 A zero operand (either input) with finite partner SHALL produce n_z=0 and n_is_inf_nan=0.

Reset
REQ-028 rst=1 at a clock edge SHALL clear every register: n_valid=0, v1=0, n_rm=0, n_sign=0, n_exp10=0, n_is_inf_nan=0, n_inf_nan_frac=0, n_z=0.
REQ-029 Reset SHALL take priority over en and flush.
REQ-030 Reset SHALL discard in-flight operations mid-pipeline; no result emerges for them.

Configuration
REQ-031 The macro FLOAT_MUL_DENORM_EN SHALL select subnormal handling.
  - Defined: subnormal operands are multiplied as 0.frac x 2^-126 per REQ-015.
  - Undefined: any operand with exponent field 0 SHALL be flushed to zero (fraction 0) before multiplication; the sign is preserved and REQ-017 applies to infinity x flushed-zero.

Verification
REQ-032 a=0x3F800000, b=0x3F800000, in_valid=1, en=1 -> after 2 edges n_valid=1, n_z=0x400000000000, n_exp10=0x07F, n_sign=0, n_is_inf_nan=0.
REQ-033 a=0x40000000, b=0xC0400000 -> n_z=0x600000000000, n_exp10=0x081, n_sign=1.
REQ-034 a=0x7F800000, b=0x00000000 -> n_is_inf_nan=1, n_inf_nan_frac=0x400000.
REQ-035 a=0x7F800000, b=0x3F800000 -> n_is_inf_nan=1, n_inf_nan_frac=0.
REQ-036 a=0x00000001, b=0x3F800000 -> n_exp10=0x001.
  - Macro defined: n_z=0x000000800000.
  - Macro undefined: n_z=0.
REQ-037 Pipeline control sequence:
  - Issue 1.0x1.0 back-to-back with 3.0x3.0.
  - Hold en=0 for 3 cycles: outputs frozen.
  - Assert flush during the stall: n_valid=0 next edge.
  - Assert rst with valid data in flight: all outputs 0 next edge and no result emerges.

Source files
------------

// File: rtl/float_mul_pipe_mul.sv
// float_mul_pipe_mul
// Two-stage front end of a single-precision floating-point multiplier.
// Stage 1 unpacks both operands and computes the product sign and biased
// exponent. It classifies infinity/NaN results and forms two 24x12 partial
// products. Stage 2 merges the partial products into the unnormalised
// 48-bit significand product and forwards the remaining fields.
// Normalisation and rounding happen downstream.
//
// Build option:
//   FLOAT_MUL_DENORM_EN  defined   : subnormals are multiplied as 0.frac x 2^-126
//                        undefined : exponent-field-0 operands are flushed to zero
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset, clears every register
//   en              pipeline advance; 0 holds every register
//   flush           clears both valid bits at the edge, regardless of en
//   in_valid        a/b/rm are valid this cycle
//   a, b            IEEE-754 single-precision operands
//   rm              rounding mode, carried through unchanged
//   n_valid         stage-2 result valid
//   n_rm            rounding mode of the stage-2 result
//   n_sign          product sign
//   n_exp10         biased product exponent, 10-bit two's complement
//   n_is_inf_nan    result is infinity or NaN
//   n_inf_nan_frac  fraction to emit when n_is_inf_nan is set
//   n_z             unnormalised 48-bit significand product

module float_mul_pipe_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    output logic        n_valid,
    output logic [1:0]  n_rm,
    output logic        n_sign,
    output logic [9:0]  n_exp10,
    output logic        n_is_inf_nan,
    output logic [22:0] n_inf_nan_frac,
    output logic [47:0] n_z
);

    localparam logic [22:0] QNAN_FRAC = 23'h400000;

    logic [7:0]  exp_a, exp_b;
    logic        a_exp_zero, b_exp_zero;
    logic        a_exp_max, b_exp_max;
    logic        a_frac_zero, b_frac_zero;
    logic        a_is_zero, b_is_zero;
    logic        a_is_inf, b_is_inf;
    logic        a_is_nan, b_is_nan;
    logic [7:0]  exp_a_eff, exp_b_eff;
    logic [23:0] frac_a, frac_b;

    logic        sign_c;
    logic [9:0]  exp10_c;
    logic        inf_nan_c;
    logic        qnan_c;
    logic [35:0] pp_lo_c, pp_hi_c;

    // Stage-1 registers
    logic        v1;
    logic [1:0]  s1_rm;
    logic        s1_sign;
    logic [9:0]  s1_exp10;
    logic        s1_inf_nan;
    logic        s1_qnan;
    logic [35:0] pp_lo, pp_hi;

    assign exp_a       = a[30:23];
    assign exp_b       = b[30:23];
    assign a_exp_zero  = (exp_a == 8'd0);
    assign b_exp_zero  = (exp_b == 8'd0);
    assign a_exp_max   = (exp_a == 8'hFF);
    assign b_exp_max   = (exp_b == 8'hFF);
    assign a_frac_zero = (a[22:0] == 23'd0);
    assign b_frac_zero = (b[22:0] == 23'd0);

    // Exponent field 0 behaves as exponent 1 in both build modes, so the
    // exponent path does not depend on subnormal handling.
    assign exp_a_eff = a_exp_zero ? 8'd1 : exp_a;
    assign exp_b_eff = b_exp_zero ? 8'd1 : exp_b;

`ifdef FLOAT_MUL_DENORM_EN
    assign frac_a    = {~a_exp_zero, a[22:0]};
    assign frac_b    = {~b_exp_zero, b[22:0]};
    assign a_is_zero = a_exp_zero & a_frac_zero;
    assign b_is_zero = b_exp_zero & b_frac_zero;
`else
    // Subnormals are flushed: the fraction is dropped, and the operand also
    // counts as zero when it meets an infinity.
    assign frac_a    = a_exp_zero ? 24'd0 : {1'b1, a[22:0]};
    assign frac_b    = b_exp_zero ? 24'd0 : {1'b1, b[22:0]};
    assign a_is_zero = a_exp_zero;
    assign b_is_zero = b_exp_zero;
`endif

    assign a_is_inf = a_exp_max & a_frac_zero;
    assign b_is_inf = b_exp_max & b_frac_zero;
    assign a_is_nan = a_exp_max & ~a_frac_zero;
    assign b_is_nan = b_exp_max & ~b_frac_zero;

    assign sign_c    = a[31] ^ b[31];
    assign exp10_c   = {2'b00, exp_a_eff} + {2'b00, exp_b_eff} - 10'd127;
    assign qnan_c    = a_is_nan | b_is_nan | (a_is_inf & b_is_zero) | (b_is_inf & a_is_zero);
    assign inf_nan_c = qnan_c | a_is_inf | b_is_inf;

    // Split the multiplier in two 12-bit halves so each stage-1 multiply is
    // only 24x12; stage 2 recombines them.
    assign pp_lo_c = {12'd0, frac_a} * {24'd0, frac_b[11:0]};
    assign pp_hi_c = {12'd0, frac_a} * {24'd0, frac_b[23:12]};

    always_ff @(posedge clk) begin
        if (rst) begin
            v1             <= 1'b0;
            s1_rm          <= 2'd0;
            s1_sign        <= 1'b0;
            s1_exp10       <= 10'd0;
            s1_inf_nan     <= 1'b0;
            s1_qnan        <= 1'b0;
            pp_lo          <= 36'd0;
            pp_hi          <= 36'd0;
            n_valid        <= 1'b0;
            n_rm           <= 2'd0;
            n_sign         <= 1'b0;
            n_exp10        <= 10'd0;
            n_is_inf_nan   <= 1'b0;
            n_inf_nan_frac <= 23'd0;
            n_z            <= 48'd0;
        end else begin
            if (en) begin
                v1             <= in_valid;
                s1_rm          <= rm;
                s1_sign        <= sign_c;
                s1_exp10       <= exp10_c;
                s1_inf_nan     <= inf_nan_c;
                s1_qnan        <= qnan_c;
                pp_lo          <= pp_lo_c;
                pp_hi          <= pp_hi_c;

                n_valid        <= v1;
                n_rm           <= s1_rm;
                n_sign         <= s1_sign;
                n_exp10        <= s1_exp10;
                n_is_inf_nan   <= s1_inf_nan;
                n_inf_nan_frac <= s1_qnan ? QNAN_FRAC : 23'd0;
                n_z            <= {12'd0, pp_lo} + {pp_hi, 12'd0};
            end
            // Flush wins over the loads above; data registers are untouched.
            if (flush) begin
                v1      <= 1'b0;
                n_valid <= 1'b0;
            end
        end
    end

endmodule
